// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
// Sprite DMA engine sitting on the CPU bus between the 6502 core and memory.
// A CPU write to DMA_REG_ADDR latches a source page and stalls the core. The
// engine then copies the 256 bytes of CPU page {page,8'h00} into the PPU OAM
// data port, one read cycle followed by one write cycle per byte. Reads are
// kept on even cycles (cycle_odd==0), so the engine inserts one alignment
// cycle when the trigger lands on the wrong parity.
//
// Ports
//   clk        in   1   system clock, all logic on posedge
//   reset      in   1   synchronous, active-high; aborts any transfer
//   cpu_wen    in   1   CPU write strobe
//   cpu_waddr  in   16  CPU write address
//   cpu_wdata  in   8   CPU write data (source page on a trigger write)
//   cpu_halt   out  1   high while a transfer is in progress
//   mem_raddr  out  16  DMA read address toward memory
//   mem_rdata  in   8   memory read data, valid the cycle after mem_raddr
//   dma_wen    out  1   one-cycle write strobe toward the OAM data port
//   dma_waddr  out  16  OAM_DATA_ADDR while dma_wen, otherwise 0
//   dma_wdata  out  8   byte written to OAM while dma_wen, otherwise 0
// -----------------------------------------------------------------------------
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_wen,
  input  logic [15:0] cpu_waddr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_halt,
  output logic [15:0] mem_raddr,
  input  logic [7:0]  mem_rdata,
  output logic        dma_wen,
  output logic [15:0] dma_waddr,
  output logic [7:0]  dma_wdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q,  page_d;
  logic [7:0]  idx_q,   idx_d;
  logic        cycle_odd_q;
  logic [15:0] raddr_q, raddr_d;

  logic        trigger;

  assign trigger = cpu_wen && (cpu_waddr == DMA_REG_ADDR);

  // ---------------------------------------------------------------------------
  // State register. cycle_odd free-runs across transfers; only reset clears it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      page_q      <= 8'h00;
      idx_q       <= 8'h00;
      cycle_odd_q <= 1'b0;
      raddr_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      idx_q       <= idx_d;
      cycle_odd_q <= ~cycle_odd_q;
      raddr_q     <= raddr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. The trigger is only looked at while IDLE is the current
  // state, so a write landing on the final WRITE cycle is dropped, and writes
  // during a transfer never touch page or restart the sequence.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    raddr_d = raddr_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          page_d  = cpu_wdata;
          idx_d   = 8'h00;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        // HALT with cycle_odd==1 puts READ on an even cycle directly;
        // otherwise one ALIGN cycle restores even-parity reads.
        state_d = cycle_odd_q ? S_READ : S_ALIGN;
      end
      S_ALIGN: begin
        state_d = S_READ;
      end
      S_READ: begin
        raddr_d = {page_q, idx_q};
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // idx wraps at 8 bits, so the source never carries into page+1.
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q == 8'hFF) ? S_IDLE : S_READ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. The read address is presented during READ and held afterwards;
  // memory returns the byte during the following WRITE cycle, where it is
  // forwarded straight to the OAM port.
  // ---------------------------------------------------------------------------
  assign cpu_halt  = (state_q != S_IDLE);
  assign mem_raddr = (state_q == S_READ) ? {page_q, idx_q} : raddr_q;
  assign dma_wen   = (state_q == S_WRITE);
  assign dma_waddr = dma_wen ? OAM_DATA_ADDR : 16'h0000;
  assign dma_wdata = dma_wen ? mem_rdata : 8'h00;

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma
// Self-checking bench for oam_dma. A 64 KiB memory model with one-cycle read
// latency feeds the engine; each transfer is measured (stall length, pulse
// count, per-byte source address, destination address and data) and compared
// against what the transfer rules predict from the page and trigger parity.
// -----------------------------------------------------------------------------
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_wen;
  logic [15:0] cpu_waddr;
  logic [7:0]  cpu_wdata;
  logic        cpu_halt;
  logic [15:0] mem_raddr;
  logic [7:0]  mem_rdata;
  logic        dma_wen;
  logic [15:0] dma_waddr;
  logic [7:0]  dma_wdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:65535];

  // parity of the current cycle as seen by the engine: 0 right after reset
  bit ref_odd = 1'b0;

  // measurements from the most recent transfer
  int         m_halt;
  int         m_wen;
  int         m_bad_data;
  int         m_bad_waddr;
  int         m_bad_raddr;
  int         m_first_bad;
  logic [7:0] m_last_data;
  int         m_exp_len;

  oam_dma dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_wen   (cpu_wen),
    .cpu_waddr (cpu_waddr),
    .cpu_wdata (cpu_wdata),
    .cpu_halt  (cpu_halt),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .dma_wen   (dma_wen),
    .dma_waddr (dma_waddr),
    .dma_wdata (dma_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_raddr];
  always @(posedge clk) ref_odd <= reset ? 1'b0 : ~ref_odd;

  // Runs one transfer from page pg. want_align selects a trigger cycle whose
  // parity forces the alignment cycle. retrig issues ignored trigger writes
  // mid-transfer and on the final write cycle. rst_at>0 raises reset on that
  // write pulse and returns immediately.
  task automatic run_xfer(input logic [7:0] pg, input bit want_align,
                          input bit retrig, input int rst_at);
    logic [15:0] prev_raddr;
    logic [7:0]  k;
    logic [15:0] src;
    bit          inj;
    m_halt = 0; m_wen = 0; m_bad_data = 0; m_bad_waddr = 0;
    m_bad_raddr = 0; m_first_bad = -1; m_last_data = 8'h00;
    prev_raddr = 16'h0000;
    inj = 1'b0;
    @(negedge clk);
    while (ref_odd != want_align) @(negedge clk);
    // reads must land on even cycles: an odd trigger cycle costs one extra
    m_exp_len = want_align ? 514 : 513;
    cpu_wen = 1'b1; cpu_waddr = 16'h4014; cpu_wdata = pg;
    @(negedge clk);
    cpu_wen = 1'b0;
    for (int c = 0; c < 700; c++) begin
      if (inj) begin cpu_wen = 1'b0; inj = 1'b0; end
      if (!cpu_halt) break;
      m_halt++;
      if (dma_wen) begin
        k   = m_wen[7:0];
        src = {pg, k};
        if (prev_raddr !== src) begin
          m_bad_raddr++;
          if (m_first_bad < 0) m_first_bad = m_wen;
        end
        if (dma_waddr !== 16'h2004) m_bad_waddr++;
        if (dma_wdata !== mem[src]) begin
          m_bad_data++;
          if (m_first_bad < 0) m_first_bad = m_wen;
        end
        m_last_data = dma_wdata;
        m_wen++;
        if (rst_at > 0 && m_wen == rst_at) begin
          reset = 1'b1;
          return;
        end
        if (retrig && m_wen == 256) begin
          cpu_wen = 1'b1; cpu_waddr = 16'h4014; cpu_wdata = 8'h07; inj = 1'b1;
        end
      end
      if (retrig && m_halt == 50) begin
        cpu_wen = 1'b1; cpu_waddr = 16'h4014; cpu_wdata = 8'h07; inj = 1'b1;
      end
      prev_raddr = mem_raddr;
      @(negedge clk);
    end
    cpu_wen = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_wen = 1'b0; cpu_waddr = 16'h0000; cpu_wdata = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (cpu_halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b want 0", cpu_halt); end
    checks++; if (mem_raddr !== 16'h0000) begin errors++; $display("FAIL reset_raddr got %h want 0000", mem_raddr); end
    checks++; if (dma_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b want 0", dma_wen); end
    checks++; if (dma_waddr !== 16'h0000) begin errors++; $display("FAIL reset_waddr got %h want 0000", dma_waddr); end
    checks++; if (dma_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h want 00", dma_wdata); end
    reset = 1'b0;
  endtask

  task automatic test_transfer(input string name, input logic [7:0] pg,
                               input bit want_align, input bit retrig);
    run_xfer(pg, want_align, retrig, 0);
    checks++; if (m_halt !== m_exp_len) begin errors++; $display("FAIL %s_len got %0d want %0d", name, m_halt, m_exp_len); end
    checks++; if (m_wen !== 256) begin errors++; $display("FAIL %s_pulses got %0d want 256", name, m_wen); end
    checks++; if (m_bad_raddr !== 0) begin errors++; $display("FAIL %s_raddr got %0d bad (first %0d) want 0", name, m_bad_raddr, m_first_bad); end
    checks++; if (m_bad_waddr !== 0) begin errors++; $display("FAIL %s_waddr got %0d bad want 0", name, m_bad_waddr); end
    checks++; if (m_bad_data !== 0) begin errors++; $display("FAIL %s_data got %0d bad (first %0d) want 0", name, m_bad_data, m_first_bad); end
  endtask

  task automatic test_odd_page2();
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
    test_transfer("no_align", 8'h02, 1'b0, 1'b0);
  endtask

  task automatic test_align_page2();
    test_transfer("align", 8'h02, 1'b1, 1'b0);
  endtask

  task automatic test_page_ff();
    mem[16'h0000] = 8'hC3;
    mem[16'hFFFF] = 8'h3C;
    test_transfer("page_ff", 8'hFF, 1'(($urandom) & 1), 1'b0);
    checks++; if (m_last_data !== mem[16'hFFFF]) begin errors++; $display("FAIL page_ff_last got %h want %h", m_last_data, mem[16'hFFFF]); end
  endtask

  task automatic test_reset_mid();
    int stray_wen;
    int stray_halt;
    run_xfer(8'h02, 1'(($urandom) & 1), 1'b0, 100);
    checks++; if (m_wen !== 100) begin errors++; $display("FAIL rst_mid_pulses got %0d want 100", m_wen); end
    @(negedge clk);
    checks++; if (cpu_halt !== 1'b0) begin errors++; $display("FAIL rst_mid_halt got %b want 0", cpu_halt); end
    checks++; if (dma_wen !== 1'b0) begin errors++; $display("FAIL rst_mid_wen got %b want 0", dma_wen); end
    checks++; if (mem_raddr !== 16'h0000) begin errors++; $display("FAIL rst_mid_raddr got %h want 0000", mem_raddr); end
    checks++; if (dma_waddr !== 16'h0000) begin errors++; $display("FAIL rst_mid_waddr got %h want 0000", dma_waddr); end
    checks++; if (dma_wdata !== 8'h00) begin errors++; $display("FAIL rst_mid_wdata got %h want 00", dma_wdata); end
    reset = 1'b0;
    stray_wen = 0; stray_halt = 0;
    repeat (600) begin
      @(negedge clk);
      if (dma_wen) stray_wen++;
      if (cpu_halt) stray_halt++;
    end
    checks++; if (stray_wen !== 0) begin errors++; $display("FAIL rst_mid_after_wen got %0d want 0", stray_wen); end
    checks++; if (stray_halt !== 0) begin errors++; $display("FAIL rst_mid_after_halt got %0d want 0", stray_halt); end
  endtask

  task automatic test_retrigger();
    int late_halt;
    for (int i = 0; i < 256; i++) mem[16'h0700 + i] = ~mem[16'h0200 + i];
    test_transfer("retrig", 8'h02, 1'(($urandom) & 1), 1'b1);
    // the write on the final WRITE cycle must not start another transfer
    late_halt = 0;
    repeat (8) begin
      @(negedge clk);
      if (cpu_halt) late_halt++;
    end
    checks++; if (late_halt !== 0) begin errors++; $display("FAIL retrig_late got %0d halt cycles want 0", late_halt); end
  endtask

  task automatic test_other_writes();
    int halt_seen;
    int wen_seen;
    logic [15:0] addrs [4];
    logic        wens  [4];
    addrs[0] = 16'h4013; wens[0] = 1'b1;
    addrs[1] = 16'h4015; wens[1] = 1'b1;
    addrs[2] = 16'h2004; wens[2] = 1'b1;
    addrs[3] = 16'h4014; wens[3] = 1'b0;
    halt_seen = 0; wen_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_wen = wens[i]; cpu_waddr = addrs[i]; cpu_wdata = 8'($urandom);
      @(negedge clk);
      cpu_wen = 1'b0;
      repeat (6) begin
        if (cpu_halt) halt_seen++;
        if (dma_wen) wen_seen++;
        @(negedge clk);
      end
    end
    checks++; if (halt_seen !== 0) begin errors++; $display("FAIL other_halt got %0d want 0", halt_seen); end
    checks++; if (wen_seen !== 0) begin errors++; $display("FAIL other_wen got %0d want 0", wen_seen); end
  endtask

  task automatic test_random();
    logic [7:0] pg;
    for (int n = 0; n < 3; n++) begin
      pg = 8'($urandom);
      test_transfer("random", pg, 1'(($urandom) & 1), 1'b0);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    test_reset();
    test_odd_page2();
    test_align_page2();
    test_page_ff();
    test_reset_mid();
    test_retrigger();
    test_other_writes();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
